// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: stage state encoding, bubble constants and the
// ID/EX payload field layout used by pipe_skid_stage and pipe_slot.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int         IDEX_PAYLOAD_W = 70;
  localparam int         IDEX_WREG_W    = 4;
  localparam int         IDEX_MEM_W     = 2;
  localparam int         PERF_CNT_W     = 16;

  // A bubble writes no register and performs no memory access.
  localparam logic [3:0] NOP_WREG = 4'b1111;
  localparam logic [1:0] NOP_MEM  = 2'b11;

  // ID/EX payload layout, LSB first: ctrl, aluop, pc, imme, rdata2, rdata1.
  localparam int IDEX_CTRL_LSB   = 0;
  localparam int IDEX_CTRL_W     = 2;
  localparam int IDEX_ALUOP_LSB  = 2;
  localparam int IDEX_ALUOP_W    = 4;
  localparam int IDEX_PC_LSB     = 6;
  localparam int IDEX_PC_W       = 16;
  localparam int IDEX_IMME_LSB   = 22;
  localparam int IDEX_IMME_W     = 16;
  localparam int IDEX_RDATA2_LSB = 38;
  localparam int IDEX_RDATA2_W   = 16;
  localparam int IDEX_RDATA1_LSB = 54;
  localparam int IDEX_RDATA1_W   = 16;

  function automatic logic [IDEX_PAYLOAD_W-1:0] pack_idex(
    input logic [IDEX_RDATA1_W-1:0] rdata1,
    input logic [IDEX_RDATA2_W-1:0] rdata2,
    input logic [IDEX_IMME_W-1:0]   imme,
    input logic [IDEX_PC_W-1:0]     pc,
    input logic [IDEX_ALUOP_W-1:0]  aluop,
    input logic [IDEX_CTRL_W-1:0]   ctrl
  );
    return {rdata1, rdata2, imme, pc, aluop, ctrl};
  endfunction

  function automatic logic [IDEX_PC_W-1:0] idex_pc(input logic [IDEX_PAYLOAD_W-1:0] p);
    return p[IDEX_PC_LSB +: IDEX_PC_W];
  endfunction

  function automatic logic [IDEX_ALUOP_W-1:0] idex_aluop(input logic [IDEX_PAYLOAD_W-1:0] p);
    return p[IDEX_ALUOP_LSB +: IDEX_ALUOP_W];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: width-parametrised register with load
// enable, updated on the falling clock edge, cleared by async active-low reset.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int W = IDEX_PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry (main + skid) pipeline stage register with registered in_ready,
// flush and bubble insertion; falling-edge clocked. Optional perf counters are
// built only when STAGE_PERF_CNT_EN is defined.
module pipe_skid_stage #(
  parameter int                 PAYLOAD_W = 70,
  parameter int                 WREG_W    = 4,
  parameter int                 MEM_W     = 2,
  parameter logic [WREG_W-1:0]  NOP_WREG  = WREG_W'(cpu_pipe_pkg::NOP_WREG),
  parameter logic [MEM_W-1:0]   NOP_MEM   = MEM_W'(cpu_pipe_pkg::NOP_MEM),
  parameter int                 CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [WREG_W-1:0]    in_wreg,
  input  logic [MEM_W-1:0]     in_mem,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [WREG_W-1:0]    out_wreg,
  output logic [MEM_W-1:0]     out_mem,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);
  import cpu_pipe_pkg::*;

  localparam int ENTRY_W = PAYLOAD_W + WREG_W + MEM_W;

  // Handshake: a transfer happens on a falling edge where valid && ready.
  // in_ready depends only on the state register, so it never combinationally
  // follows out_ready; the skid slot absorbs the one entry in flight.
  stage_state_e       state;
  logic               accept;
  logic               pop;
  logic               main_load;
  logic               skid_load;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_entry  = {in_payload, in_wreg, in_mem};

  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_entry;
    if (!flush) begin
      case (state)
        EMPTY: main_load = accept;
        ONE: begin
          main_load = accept && pop;
          skid_load = accept && !pop;
        end
        TWO: begin
          main_load = pop;
          main_d    = skid_q;
        end
        default: begin
          main_load = 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !pop) state <= TWO;
          else if (!accept && pop) state <= EMPTY;
        end
        TWO: if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(ENTRY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_slot #(.W(ENTRY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_entry),
    .q    (skid_q)
  );

  // Payload is left as-is when empty; only the control fields become a bubble.
  assign out_payload = main_q[ENTRY_W-1 -: PAYLOAD_W];
  assign out_wreg    = out_valid ? main_q[MEM_W +: WREG_W] : NOP_WREG;
  assign out_mem     = out_valid ? main_q[0 +: MEM_W]      : NOP_MEM;

`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!out_valid && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, back-pressure, flush,
// async reset and perf counters (expectations follow STAGE_PERF_CNT_EN).
`timescale 1ns/1ps
module tb_pipe_skid_stage;

  localparam int PW = 70;
  localparam int WW = 4;
  localparam int MW = 2;
  localparam int CW = 16;
`ifdef STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_payload = '0;
  logic [WW-1:0] in_wreg = '0;
  logic [MW-1:0] in_mem = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_payload;
  logic [WW-1:0] out_wreg;
  logic [MW-1:0] out_mem;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  int compared = 0;
  int mismatched = 0;

  pipe_skid_stage #(
    .PAYLOAD_W (PW),
    .WREG_W    (WW),
    .MEM_W     (MW),
    .NOP_WREG  (4'b1111),
    .NOP_MEM   (2'b11),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_wreg     (in_wreg),
    .in_mem      (in_mem),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_wreg    (out_wreg),
    .out_mem     (out_mem),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  // Clock/reset: the DUT is active on the falling edge.
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] p, input logic [WW-1:0] w,
                       input logic [MW-1:0] m);
    in_valid   = v;
    in_payload = p;
    in_wreg    = w;
    in_mem     = m;
  endtask

  task automatic test_reset();
    #2;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    compared++; if (out_payload !== '0) begin mismatched++; $display("FAIL reset_payload got %0h exp 0", out_payload); end
    compared++; if (out_wreg !== 4'hF) begin mismatched++; $display("FAIL reset_wreg got %0h exp f", out_wreg); end
    compared++; if (out_mem !== 2'b11) begin mismatched++; $display("FAIL reset_mem got %0h exp 3", out_mem); end
    compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    compared++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin mismatched++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, bubble_cnt); end
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, PW'(i), WW'(i), MW'(i));
      step();
      compared++; if (out_valid !== 1'b1 || out_payload !== PW'(i)) begin mismatched++; $display("FAIL stream_payload[%0d] got v=%0b %0h exp v=1 %0h", i, out_valid, out_payload, i); end
      compared++; if (out_wreg !== WW'(i) || out_mem !== MW'(i)) begin mismatched++; $display("FAIL stream_ctrl[%0d] got %0h/%0h exp %0h/%0h", i, out_wreg, out_mem, WW'(i), MW'(i)); end
      compared++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp occ=1 rdy=1", i, occupancy, in_ready); end
    end
    drive(1'b0, '0, '0, '0);
    step();
    compared++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin mismatched++; $display("FAIL stream_drain got v=%0b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    compared++; if (out_wreg !== 4'hF || out_mem !== 2'b11) begin mismatched++; $display("FAIL stream_bubble got %0h/%0h exp f/3", out_wreg, out_mem); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, PW'('hA1), 4'd1, 2'd0);
    step();
    compared++; if (occupancy !== 2'd1 || out_payload !== PW'('hA1)) begin mismatched++; $display("FAIL bp_load_a got occ=%0d %0h exp occ=1 a1", occupancy, out_payload); end
    drive(1'b1, PW'('hB2), 4'd2, 2'd1);
    step();
    compared++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full got occ=%0d rdy=%0b exp occ=2 rdy=0", occupancy, in_ready); end
    compared++; if (out_payload !== PW'('hA1) || out_wreg !== 4'd1) begin mismatched++; $display("FAIL bp_head got %0h/%0h exp a1/1", out_payload, out_wreg); end
    drive(1'b1, PW'('hC3), 4'd3, 2'd2);
    step();
    compared++; if (occupancy !== 2'd2 || out_payload !== PW'('hA1)) begin mismatched++; $display("FAIL bp_hold_c got occ=%0d %0h exp occ=2 a1", occupancy, out_payload); end
    out_ready = 1'b1;
    step();
    compared++; if (out_payload !== PW'('hB2) || out_wreg !== 4'd2 || out_mem !== 2'd1) begin mismatched++; $display("FAIL bp_out_b got %0h/%0h/%0h exp b2/2/1", out_payload, out_wreg, out_mem); end
    compared++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_after_b got occ=%0d rdy=%0b exp occ=1 rdy=1", occupancy, in_ready); end
    step();
    compared++; if (out_payload !== PW'('hC3) || out_wreg !== 4'd3 || occupancy !== 2'd1) begin mismatched++; $display("FAIL bp_out_c got %0h/%0h occ=%0d exp c3/3 occ=1", out_payload, out_wreg, occupancy); end
    drive(1'b0, '0, '0, '0);
    step();
    compared++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain got occ=%0d v=%0b exp 0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, PW'('h11), 4'd5, 2'd1);
    step();
    drive(1'b1, PW'('h22), 4'd6, 2'd2);
    step();
    compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL flush_prefill got occ=%0d exp 2", occupancy); end
    flush = 1'b1;
    drive(1'b1, PW'('hDD), 4'd7, 2'd0);
    step();
    compared++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_full got v=%0b occ=%0d rdy=%0b exp 0/0/1", out_valid, occupancy, in_ready); end
    compared++; if (out_wreg !== 4'hF || out_mem !== 2'b11) begin mismatched++; $display("FAIL flush_bubble got %0h/%0h exp f/3", out_wreg, out_mem); end
    compared++; if (out_payload !== PW'('h11)) begin mismatched++; $display("FAIL flush_payload_kept got %0h exp 11", out_payload); end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    step();
    compared++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_d_lost got occ=%0d v=%0b exp 0/0", occupancy, out_valid); end
    // Flush while accepting in ONE: the incoming entry must be discarded too.
    drive(1'b1, PW'('h33), 4'd8, 2'd0);
    step();
    flush = 1'b1;
    drive(1'b1, PW'('h44), 4'd9, 2'd1);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    compared++; if (occupancy !== 2'd0 || out_payload !== PW'('h33)) begin mismatched++; $display("FAIL flush_accept got occ=%0d %0h exp occ=0 33", occupancy, out_payload); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, PW'('h77), 4'd7, 2'd1);
    step();
    drive(1'b0, '0, '0, '0);
    compared++; if (occupancy !== 2'd1 || out_valid !== 1'b1) begin mismatched++; $display("FAIL arst_pre got occ=%0d v=%0b exp 1/1", occupancy, out_valid); end
    #3 rst = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL arst_now got v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
    compared++; if (occupancy !== 2'd0 || out_wreg !== 4'hF || out_payload !== '0) begin mismatched++; $display("FAIL arst_state got occ=%0d %0h %0h exp 0 f 0", occupancy, out_wreg, out_payload); end
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_counters();
    logic [CW-1:0] exp_bub [5];
    logic [CW-1:0] exp_stl [5];
    exp_bub = '{16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
    exp_stl = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
    rst = 1'b0;
    #2 rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive(1'b1, PW'('h55), 4'd5, 2'd0);
      else drive(1'b0, '0, '0, '0);
      step();
      compared++;
      if (stall_cnt !== (PERF ? exp_stl[k] : 16'd0) || bubble_cnt !== (PERF ? exp_bub[k] : 16'd0)) begin
        mismatched++;
        $display("FAIL cnt_step[%0d] got stall=%0d bubble=%0d exp stall=%0d bubble=%0d", k, stall_cnt, bubble_cnt,
                 PERF ? exp_stl[k] : 16'd0, PERF ? exp_bub[k] : 16'd0);
      end
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    compared++;
    if (stall_cnt !== (PERF ? 16'd4 : 16'd0) || bubble_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      mismatched++;
      $display("FAIL cnt_flush_keep got stall=%0d bubble=%0d", stall_cnt, bubble_cnt);
    end
`ifdef STAGE_PERF_CNT_EN
    drive(1'b1, PW'('h66), 4'd6, 2'd0);
    step();
    drive(1'b0, '0, '0, '0);
    repeat (65540) @(negedge clk);
    #1;
    compared++; if (stall_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL cnt_saturate got %0h exp ffff", stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
